decoder_n_scan: RTL and testbench
=================================

Name: decoder_n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Adds an auto-scan mode: the active output steps through every channel, holds each for a programmable dwell time, and wraps.
- Drives channel-select strobes for multiplexed peripherals such as display digits or bank selects, where plain combinational decoders were used before.

Parameters:
- N, 2, select width; output width is 2^N (N >= 1).
- DWELL, 4, cycles each channel stays active in scan mode (DWELL >= 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; 0 forces all outputs inactive from the next cycle.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- sel  in  N  direct channel index; also the scan start index.
- y  out  2^N  registered one-hot select; all zero when idle.
- idx  out  N  index of the currently active channel.
- step  out  1  one-cycle pulse when scan advances to the next channel.
- wrap  out  1  one-cycle pulse when scan advances from 2^N-1 to 0.

Behaviour:
- Reset values: y=0, idx=0, step=0, wrap=0, state=IDLE, dwell counter=0. rst has priority over every other input.
- All outputs are registered. Latency from input change to output is 1 cycle.
- FSM states: IDLE, DIRECT, SCAN. Transitions are evaluated at every rising edge:
  - en=0 -> IDLE from any state; y=0; idx holds its value.
  - en=1, mode=0 -> DIRECT; idx<=sel; y<=onehot(sel). sel is tracked every cycle.
  - en=1, mode=1, state!=SCAN -> SCAN; idx<=sel; y<=onehot(sel); cnt<=0.
  - en=1, mode=1, state==SCAN:
    - If cnt==DWELL-1: cnt<=0; idx<=idx+1 modulo 2^N; y<=onehot(idx+1); step<=1; wrap<=1 only if the old idx was 2^N-1.
    - Otherwise: cnt<=cnt+1; y, idx hold; step=wrap=0.
- Each channel is active for exactly DWELL cycles, including the first channel after scan entry.
- sel changes during SCAN are ignored.
- Switching SCAN->DIRECT takes effect next cycle. Switching DIRECT->SCAN restarts from the current sel with a full dwell.
- Wrap-around is natural modulo 2^N on an N-bit idx. No out-of-range index is possible.
- DWELL=1: advance every cycle; step is high continuously while scanning; wrap pulses every 2^N cycles.
- Dwell counter width is max(1, clog2(DWELL)).
- Leaving SCAN by any route clears cnt, step and wrap.
- Reset mid-scan: outputs go to reset values on the reset edge. After release, the first enabled edge restarts the scan from sel.
- Invariant: popcount(y) is 0 in IDLE and 1 otherwise, and y==onehot(idx) whenever state!=IDLE.

Decomposition:
- Shared package:
  - state enum {IDLE, DIRECT, SCAN};
  - onehot function (N -> 2^N);
  - DWELL counter-width helper.
- One sub-module: dwell_counter. It has parameter DWELL, inputs clk/rst/clr/inc, and output done (cnt==DWELL-1). Reused by other timed sequencers.
- Decode and FSM stay in the top module.

Test Plan (N=2, DWELL=3 unless noted):
- Reset: rst=1 for 2 cycles with en=1, mode=1 -> y=4'b0000, idx=0, step=0, wrap=0 throughout.
- Direct: en=1, mode=0, sel=2 at edge k -> y=4'b0100, idx=2 from k+1. sel=3 at k+1 -> y=4'b1000 from k+2. en=0 at k+2 -> y=0 from k+3.
- Scan sequence: en=1, mode=1, sel=1 at edge k ->
  - y=0010 for cycles k+1..k+3;
  - 0100 for k+4..k+6 (step=1 at k+4);
  - 1000 for k+7..k+9;
  - 0001 from k+10, with step=1 and wrap=1 only at k+10.
- Interrupt: drop en during the second channel -> y=0 next cycle. Re-assert with sel=3 -> y=1000 held for 3 full cycles, then 0001 with wrap=1.
- Mode switch and reset mid-scan:
  - mode 1->0 with sel=0 -> y=0001 next cycle, step=wrap=0.
  - rst=1 mid-scan -> reset values. Release with en=1, mode=1, sel=2 -> y=0100 restarts with full dwell.
- Parametrisation: N=3, DWELL=1, sel=6 -> y=0x40, 0x80, 0x01 on consecutive cycles. wrap every 8 cycles, step constantly 1, popcount(y)=1 every cycle.

Source files
------------

// File: rtl/decoder_n_scan_pkg.sv
// Shared types and helpers for the decoder/scan block and its timed sequencers.
package decoder_n_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Widest select the onehot helper supports; callers slice the low 2^N bits.
    localparam int MAX_N = 10;
    localparam int MAX_W = 1 << MAX_N;

    // One-hot decode of an index into a MAX_W-wide vector.
    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] i);
        logic [MAX_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Counter width able to hold 0..dwell-1, never narrower than one bit.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_n_scan_dwell_counter.sv
// Dwell timer: counts enabled cycles and flags the last cycle of a dwell period.
module dwell_counter
    import decoder_n_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int            CW   = dwell_cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Count up while inc is held, restarting after the final dwell cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot channel decoder with an auto-scan mode that
// steps through every channel, holding each for DWELL cycles.
module decoder_n_scan
    import decoder_n_scan_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              step,
    output logic              wrap
);

    localparam int           W        = 1 << N;
    localparam logic [N-1:0] LAST_IDX = '1;

    state_t           state;
    logic             scanning;
    logic             cnt_done;
    logic [N-1:0]     idx_nxt;
    logic [MAX_W-1:0] oh_sel;
    logic [MAX_W-1:0] oh_nxt;

    // Dwell timing only runs while a scan is already in progress; any other
    // cycle (entry, direct, idle) restarts it so every channel gets a full dwell.
    assign scanning = en && mode && (state == SCAN);

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (!scanning),
        .inc (scanning),
        .done(cnt_done)
    );

    // Next-channel index and the two candidate one-hot patterns.
    always_comb begin
        idx_nxt = idx + N'(1);
        oh_sel  = onehot(MAX_N'(sel));
        oh_nxt  = onehot(MAX_N'(idx_nxt));
    end

    // Mode FSM with registered select, index and scan pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            idx   <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            y     <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state <= DIRECT;
            idx   <= sel;
            y     <= oh_sel[W-1:0];
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (state != SCAN) begin
            state <= SCAN;
            idx   <= sel;
            y     <= oh_sel[W-1:0];
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (cnt_done) begin
            idx   <= idx_nxt;
            y     <= oh_nxt[W-1:0];
            step  <= 1'b1;
            wrap  <= (idx == LAST_IDX);
        end else begin
            step  <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: a directed vector table on an N=2/DWELL=3 instance,
// a hand sequence on an N=3/DWELL=1 instance, then random stimulus on both
// checked against a timeline model of the scan behaviour.
module tb_decoder_n_scan;

    localparam int K_IDLE = 0;
    localparam int K_DIR  = 1;
    localparam int K_SCAN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, DWELL=3
    logic       a_rst, a_en, a_mode;
    logic [1:0] a_sel;
    logic [3:0] a_y;
    logic [1:0] a_idx;
    logic       a_step, a_wrap;

    // Instance B: N=3, DWELL=1
    logic       b_rst, b_en, b_mode;
    logic [2:0] b_sel;
    logic [7:0] b_y;
    logic [2:0] b_idx;
    logic       b_step, b_wrap;

    decoder_n_scan #(.N(2), .DWELL(3)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .sel(a_sel),
        .y(a_y), .idx(a_idx), .step(a_step), .wrap(a_wrap)
    );

    decoder_n_scan #(.N(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .sel(b_sel),
        .y(b_y), .idx(b_idx), .step(b_step), .wrap(b_wrap)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: the active channel is start + floor(elapsed/dwell) mod 2^N, where
    // elapsed counts edges since the scan was entered.
    typedef struct {
        int kind;
        int start;
        int elapsed;
        int idx;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mstep(mst_t s, logic rst, logic en, logic mode,
                                   int sel, int dwell, int m);
        mst_t n;
        n = s;
        if (rst) begin
            n.kind = K_IDLE; n.idx = 0; n.elapsed = 0;
        end else if (!en) begin
            n.kind = K_IDLE;
        end else if (!mode) begin
            n.kind = K_DIR; n.idx = sel;
        end else if (s.kind != K_SCAN) begin
            n.kind = K_SCAN; n.start = sel; n.elapsed = 0; n.idx = sel;
        end else begin
            n.elapsed = s.elapsed + 1;
            n.idx = (s.start + n.elapsed / dwell) % m;
        end
        return n;
    endfunction

    task automatic cmp_model(input string nm, input mst_t s, input int dwell,
                             input int y, input int idx, input int st, input int wr);
        int ey, es, ew;
        ey = (s.kind == K_IDLE) ? 0 : (1 << s.idx);
        es = (s.kind == K_SCAN && s.elapsed > 0 && (s.elapsed % dwell) == 0) ? 1 : 0;
        ew = (es == 1 && s.idx == 0) ? 1 : 0;
        chk({nm, ".y"}, y, ey);
        chk({nm, ".idx"}, idx, s.idx);
        chk({nm, ".step"}, st, es);
        chk({nm, ".wrap"}, wr, ew);
    endtask

    // One clock: sample just after the edge, advance both models, compare.
    task automatic tick();
        @(posedge clk);
        #1;
        ma = mstep(ma, a_rst, a_en, a_mode, int'(a_sel), 3, 4);
        mb = mstep(mb, b_rst, b_en, b_mode, int'(b_sel), 1, 8);
        cmp_model("modelA", ma, 3, int'(a_y), int'(a_idx), int'(a_step), int'(a_wrap));
        cmp_model("modelB", mb, 1, int'(b_y), int'(b_idx), int'(b_step), int'(b_wrap));
        chk("popB", $countones(b_y), (mb.kind == K_IDLE) ? 0 : 1);
    endtask

    typedef struct {
        logic       rst, en, mode;
        logic [1:0] sel;
        logic [3:0] y;
        logic [1:0] idx;
        logic       step, wrap;
    } vec_t;

    function automatic vec_t v(int r, int e, int m, int s, logic [3:0] ey,
                               int ei, int es, int ew);
        vec_t t;
        t.rst = r[0]; t.en = e[0]; t.mode = m[0]; t.sel = s[1:0];
        t.y = ey; t.idx = ei[1:0]; t.step = es[0]; t.wrap = ew[0];
        return t;
    endfunction

    vec_t tbl[34];

    initial begin
        int wraps;
        ma = '{kind: K_IDLE, start: 0, elapsed: 0, idx: 0};
        mb = ma;

        // inputs applied before an edge -> outputs expected after it
        tbl[0]  = v(1,1,1,3, 4'b0000,0,0,0);  // reset with en/mode high
        tbl[1]  = v(1,1,1,3, 4'b0000,0,0,0);
        tbl[2]  = v(0,1,0,2, 4'b0100,2,0,0);  // direct
        tbl[3]  = v(0,1,0,3, 4'b1000,3,0,0);
        tbl[4]  = v(0,0,0,3, 4'b0000,3,0,0);  // disable, idx holds
        tbl[5]  = v(0,1,1,1, 4'b0010,1,0,0);  // scan entry from sel=1
        tbl[6]  = v(0,1,1,0, 4'b0010,1,0,0);  // sel ignored while scanning
        tbl[7]  = v(0,1,1,2, 4'b0010,1,0,0);
        tbl[8]  = v(0,1,1,0, 4'b0100,2,1,0);
        tbl[9]  = v(0,1,1,0, 4'b0100,2,0,0);
        tbl[10] = v(0,1,1,0, 4'b0100,2,0,0);
        tbl[11] = v(0,1,1,0, 4'b1000,3,1,0);
        tbl[12] = v(0,1,1,0, 4'b1000,3,0,0);
        tbl[13] = v(0,1,1,0, 4'b1000,3,0,0);
        tbl[14] = v(0,1,1,0, 4'b0001,0,1,1);  // wrap 3 -> 0
        tbl[15] = v(0,1,1,0, 4'b0001,0,0,0);
        tbl[16] = v(0,0,1,0, 4'b0000,0,0,0);
        tbl[17] = v(0,1,1,0, 4'b0001,0,0,0);  // new scan from 0
        tbl[18] = v(0,1,1,0, 4'b0001,0,0,0);
        tbl[19] = v(0,1,1,0, 4'b0001,0,0,0);
        tbl[20] = v(0,1,1,0, 4'b0010,1,1,0);  // second channel
        tbl[21] = v(0,0,1,0, 4'b0000,1,0,0);  // interrupt
        tbl[22] = v(0,1,1,3, 4'b1000,3,0,0);  // re-enter from 3, full dwell
        tbl[23] = v(0,1,1,1, 4'b1000,3,0,0);
        tbl[24] = v(0,1,1,1, 4'b1000,3,0,0);
        tbl[25] = v(0,1,1,1, 4'b0001,0,1,1);
        tbl[26] = v(0,1,0,0, 4'b0001,0,0,0);  // scan -> direct
        tbl[27] = v(0,1,1,2, 4'b0100,2,0,0);  // direct -> scan
        tbl[28] = v(0,1,1,2, 4'b0100,2,0,0);
        tbl[29] = v(1,1,1,2, 4'b0000,0,0,0);  // reset mid-scan
        tbl[30] = v(0,1,1,2, 4'b0100,2,0,0);  // restart with full dwell
        tbl[31] = v(0,1,1,1, 4'b0100,2,0,0);
        tbl[32] = v(0,1,1,1, 4'b0100,2,0,0);
        tbl[33] = v(0,1,1,1, 4'b1000,3,1,0);

        a_rst = 1'b1; a_en = 1'b0; a_mode = 1'b0; a_sel = '0;
        b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_sel = '0;

        // Directed table on instance A; B held in reset
        for (int i = 0; i < 34; i++) begin
            a_rst = tbl[i].rst; a_en = tbl[i].en; a_mode = tbl[i].mode; a_sel = tbl[i].sel;
            tick();
            chk($sformatf("vec%0d.y", i),    int'(a_y),    int'(tbl[i].y));
            chk($sformatf("vec%0d.idx", i),  int'(a_idx),  int'(tbl[i].idx));
            chk($sformatf("vec%0d.step", i), int'(a_step), int'(tbl[i].step));
            chk($sformatf("vec%0d.wrap", i), int'(a_wrap), int'(tbl[i].wrap));
        end

        // Instance B: DWELL=1 scan from 6
        a_en = 1'b0; a_rst = 1'b0;
        b_rst = 1'b0; b_en = 1'b1; b_mode = 1'b1; b_sel = 3'd6;
        tick();
        chk("b_seq0.y", int'(b_y), 'h40); chk("b_seq0.step", int'(b_step), 0);
        b_sel = 3'd1;
        tick();
        chk("b_seq1.y", int'(b_y), 'h80); chk("b_seq1.step", int'(b_step), 1);
        chk("b_seq1.wrap", int'(b_wrap), 0);
        tick();
        chk("b_seq2.y", int'(b_y), 'h01); chk("b_seq2.step", int'(b_step), 1);
        chk("b_seq2.wrap", int'(b_wrap), 1);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b_run.step", int'(b_step), 1);
            chk("b_run.pop", $countones(b_y), 1);
            if (b_wrap) wraps++;
        end
        chk("b_run.wraps16", wraps, 2);

        // Random stimulus on both instances
        for (int i = 0; i < 400; i++) begin
            a_rst = ($urandom_range(0, 49) == 0);
            a_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) a_mode = ~a_mode;
            a_sel = 2'($urandom_range(0, 3));
            b_rst = ($urandom_range(0, 49) == 0);
            b_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) b_mode = ~b_mode;
            b_sel = 3'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
